// File: rtl/bin_morph_3x3_pkg.sv
// Shared VIP constants and helpers for the 3x3 binary morphology stage.
package bin_morph_3x3_pkg;

    localparam logic MORPH_ERODE  = 1'b0;
    localparam logic MORPH_DILATE = 1'b1;

    localparam int         ROW_W   = 16;
    localparam logic [7:0] PIX_ON  = 8'hFF;
    localparam logic [7:0] PIX_OFF = 8'h00;

    // Erosion keeps a pixel only if the whole window is set; dilation if any bit is set.
    function automatic logic morph_reduce(input logic [8:0] win, input logic mode);
        return (mode == MORPH_DILATE) ? (|win) : (&win);
    endfunction

endpackage

// File: rtl/bin_morph_3x3_line_buf.sv
// One-bit-wide line store with a single shared address and registered, read-first output.
module bin_line_buf #(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          din,
    output logic          dout
);

    logic r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        dout <= r_mem[addr];
    end

endmodule

// File: rtl/bin_morph_3x3.sv
// 3x3 binary erosion/dilation over a 0/255 pixel stream; two buffered lines, 2-cycle latency.
module bin_morph_3x3
    import bin_morph_3x3_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int MODE      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_hsync,
    input  logic       pre_frame_de,
    input  logic [7:0] img_bin,
    output logic       post_frame_vsync,
    output logic       post_frame_hsync,
    output logic       post_frame_de,
    output logic [7:0] img_out
);

    localparam int              CW         = $clog2(IMG_WIDTH) + 1;
    localparam int              AW         = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0]   LP_COL_MAX = CW'(IMG_WIDTH);
    localparam logic [CW-1:0]   LP_COL_TWO = CW'(2);
    localparam logic [ROW_W-1:0] LP_ROW_TWO = ROW_W'(2);
    localparam logic            LP_MODE    = (MODE != 0) ? MORPH_DILATE : MORPH_ERODE;

    logic             w_pix;
    logic             w_vs_rise;
    logic             w_de_fall;
    logic             w_col_ok;
    logic             w_shift;
    logic             w_keep;
    logic [AW-1:0]    w_addr;
    logic             w_sel;
    logic             w_we0;
    logic             w_we1;
    logic             w_dout0;
    logic             w_dout1;
    logic             w_unused;

    logic             r_de_d1;
    logic             r_vs_d1;
    logic [CW-1:0]    r_col;
    logic [ROW_W-1:0] r_row;
    logic [IMG_WIDTH-1:0] r_sel;

    logic             r_vld_p1;
    logic             r_keep_p1;
    logic             r_p_p1;
    logic             r_sel_p1;
    logic             r_vs_p1;
    logic             r_hs_p1;
    logic             r_de_p1;

    logic             w_a;
    logic             w_b;
    logic [2:0]       w_newcol;
    logic [8:0]       w_win;
    logic             w_res;
    logic [1:0][2:0]  r_win;

    assign w_pix     = img_bin[7];
    assign w_unused  = ^img_bin[6:0];
    assign w_vs_rise = pre_frame_vsync & ~r_vs_d1;
    assign w_de_fall = r_de_d1 & ~pre_frame_de;
    assign w_col_ok  = (r_col < LP_COL_MAX);
    assign w_shift   = pre_frame_de & w_col_ok & ~rst;
    assign w_keep    = pre_frame_de & w_col_ok & (r_row >= LP_ROW_TWO) & (r_col >= LP_COL_TWO);
    assign w_addr    = w_col_ok ? r_col[AW-1:0] : '0;

    // Column/row position of the incoming pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_de_d1 <= 1'b0;
            r_vs_d1 <= 1'b0;
        end else begin
            r_de_d1 <= pre_frame_de;
            r_vs_d1 <= pre_frame_vsync;
            if (pre_frame_de) begin
                if (r_col != LP_COL_MAX) begin
                    r_col <= r_col + CW'(1);
                end
            end else if (r_de_d1) begin
                r_col <= '0;
            end
            if (w_vs_rise) begin
                r_row <= '0;
            end else if (w_de_fall && (r_row != '1)) begin
                r_row <= r_row + ROW_W'(1);
            end
        end
    end

    // lb0/lb1 swap roles per column instead of copying row-1 into row-2: r_sel[c]=1 means
    // lb1 holds the newer line at c, so the new pixel overwrites the older buffer in the
    // same cycle both are read. This keeps every buffer access on a single address.
    assign w_sel = r_sel[w_addr];
    assign w_we0 = w_shift &  w_sel;
    assign w_we1 = w_shift & ~w_sel;

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_sel[w_addr] <= ~w_sel;
        end
    end

    bin_line_buf #(.DEPTH(IMG_WIDTH), .AW(AW)) lb0 (
        .clk  (clk),
        .we   (w_we0),
        .addr (w_addr),
        .din  (w_pix),
        .dout (w_dout0)
    );

    bin_line_buf #(.DEPTH(IMG_WIDTH), .AW(AW)) lb1 (
        .clk  (clk),
        .we   (w_we1),
        .addr (w_addr),
        .din  (w_pix),
        .dout (w_dout1)
    );

    // Stage 0 -> 1: buffer read issued above, pixel and framing captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_keep_p1 <= 1'b0;
            r_p_p1    <= 1'b0;
            r_sel_p1  <= 1'b0;
            r_vs_p1   <= 1'b0;
            r_hs_p1   <= 1'b0;
            r_de_p1   <= 1'b0;
        end else begin
            r_vld_p1  <= w_shift;
            r_keep_p1 <= w_keep;
            r_p_p1    <= w_pix;
            r_sel_p1  <= w_sel;
            r_vs_p1   <= pre_frame_vsync;
            r_hs_p1   <= pre_frame_hsync;
            r_de_p1   <= pre_frame_de;
        end
    end

    assign w_b      = r_sel_p1 ? w_dout1 : w_dout0;
    assign w_a      = r_sel_p1 ? w_dout0 : w_dout1;
    assign w_newcol = {w_a, w_b, r_p_p1};
    assign w_win    = {r_win[0], r_win[1], w_newcol};
    assign w_res    = morph_reduce(w_win, LP_MODE);

    // Stage 1 -> 2: window shift and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win            <= '0;
            img_out          <= PIX_OFF;
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_de    <= 1'b0;
        end else begin
            if (r_vld_p1) begin
                r_win[0] <= r_win[1];
                r_win[1] <= w_newcol;
            end
            img_out          <= (r_keep_p1 && w_res) ? PIX_ON : PIX_OFF;
            post_frame_vsync <= r_vs_p1;
            post_frame_hsync <= r_hs_p1;
            post_frame_de    <= r_de_p1;
        end
    end

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Bench for bin_morph_3x3: erode and dilate instances share one stream and are checked
// every cycle against a frame-level reference plus per-line expected output masks.
module tb_bin_morph_3x3;

    localparam int W = 8;

    logic       clk;
    logic       rst;
    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] img;
    logic       e_vs, e_hs, e_de, d_vs, d_hs, d_de;
    logic [7:0] e_out, d_out;

    bin_morph_3x3 #(.IMG_WIDTH(W), .MODE(0)) u_ero (
        .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
        .img_bin(img), .post_frame_vsync(e_vs), .post_frame_hsync(e_hs), .post_frame_de(e_de),
        .img_out(e_out)
    );

    bin_morph_3x3 #(.IMG_WIDTH(W), .MODE(1)) u_dil (
        .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
        .img_bin(img), .post_frame_vsync(d_vs), .post_frame_hsync(d_hs), .post_frame_de(d_de),
        .img_out(d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state: position counters and the per-column two-line history
    int          m_row, m_col;
    bit          m_de_d1, m_vs_d1;
    bit          m_lb0 [W];
    bit          m_lb1 [W];
    bit [2:0]    m_colv [W];
    logic [10:0] prev_e, prev_d;
    bit          prev_tag;
    int          prev_line, prev_col;

    logic [15:0] cap_e [16];
    logic [15:0] cap_d [16];

    int          g_n, g_rst_line, g_rst_col, g_vs_line;
    int          g_w   [16];
    logic [15:0] g_img [16];
    logic [15:0] g_ee  [16];
    logic [15:0] g_ed  [16];

    typedef struct packed {
        logic [7:0]      h;
        logic [5:0][7:0] img;
        logic [5:0][7:0] ero;
        logic [5:0][7:0] dil;
    } vec_t;
    vec_t tbl [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit h, input bit d, input bit p,
                        input int line, input int pcol);
        logic [10:0] re, rd, xe, xd;
        bit vld, keep, a, b;
        int ones;
        rst = r; vs = v; hs = h; de = d;
        img = {p, 7'($urandom)};
        re = '0;
        rd = '0;
        if (r) begin
            m_row = 0; m_col = 0; m_de_d1 = 0; m_vs_d1 = 0;
        end else begin
            vld  = d && (m_col < W);
            keep = vld && (m_row >= 2) && (m_col >= 2);
            if (vld) begin
                a = m_lb1[m_col];
                b = m_lb0[m_col];
                m_lb1[m_col] = b;
                m_lb0[m_col] = p;
                m_colv[m_col] = {a, b, p};
            end
            ones = 0;
            if (keep) for (int k = m_col - 2; k <= m_col; k++) ones += $countones(m_colv[k]);
            re = {v, h, d, (keep && ones == 9) ? 8'hFF : 8'h00};
            rd = {v, h, d, (keep && ones > 0)  ? 8'hFF : 8'h00};
            if (v && !m_vs_d1) m_row = 0;
            else if (m_de_d1 && !d && m_row < 65535) m_row++;
            if (d) begin
                if (m_col < W) m_col++;
            end else if (m_de_d1) begin
                m_col = 0;
            end
            m_de_d1 = d;
            m_vs_d1 = v;
        end
        @(posedge clk);
        @(negedge clk);
        xe = r ? 11'd0 : prev_e;
        xd = r ? 11'd0 : prev_d;
        chk("erode stream", {21'd0, e_vs, e_hs, e_de, e_out}, {21'd0, xe});
        chk("dilate stream", {21'd0, d_vs, d_hs, d_de, d_out}, {21'd0, xd});
        if (!r && prev_tag) begin
            cap_e[prev_line][prev_col] = (e_out != 8'h00);
            cap_d[prev_line][prev_col] = (d_out != 8'h00);
        end
        prev_e    = r ? 11'd0 : re;
        prev_d    = r ? 11'd0 : rd;
        prev_tag  = !r && d && (line >= 0) && (pcol >= 0) && (pcol < 16);
        prev_line = line;
        prev_col  = pcol;
    endtask

    task automatic blank();
        step(0, 0, 1, 0, 0, -1, -1);
        step(0, 0, 0, 0, 0, -1, -1);
        step(0, 0, 0, 0, 0, -1, -1);
    endtask

    task automatic vsync_pulse();
        step(0, 1, 0, 0, 0, -1, -1);
        step(0, 1, 0, 0, 0, -1, -1);
        step(0, 0, 0, 0, 0, -1, -1);
        step(0, 0, 0, 0, 0, -1, -1);
    endtask

    task automatic run_case(input string nm);
        for (int i = 0; i < 16; i++) begin
            cap_e[i] = '0;
            cap_d[i] = '0;
        end
        vsync_pulse();
        for (int l = 0; l < g_n; l++) begin
            if (l == g_vs_line) vsync_pulse();
            for (int c = 0; c < g_w[l]; c++)
                step((l == g_rst_line) && (c == g_rst_col), 0, 0, 1, g_img[l][c], l, c);
            blank();
        end
        blank();
        for (int l = 0; l < g_n; l++) begin
            chk($sformatf("%s erode line%0d", nm, l), {16'd0, cap_e[l]}, {16'd0, g_ee[l]});
            chk($sformatf("%s dilate line%0d", nm, l), {16'd0, cap_d[l]}, {16'd0, g_ed[l]});
        end
    endtask

    task automatic clear_g();
        g_rst_line = -1; g_rst_col = -1; g_vs_line = -1;
        for (int i = 0; i < 16; i++) begin
            g_w[i] = W; g_img[i] = '0; g_ee[i] = '0; g_ed[i] = '0;
        end
    endtask

    initial begin
        prev_e = '0; prev_d = '0; prev_tag = 0; prev_line = 0; prev_col = 0;
        m_row = 0; m_col = 0; m_de_d1 = 0; m_vs_d1 = 0;
        rst = 1; vs = 0; hs = 0; de = 0; img = '0;

        // rows listed index 5 first; bit c of a row byte is column c
        tbl[0] = {8'd4,
                  {8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                  {8'h00, 8'h00, 8'hFC, 8'hFC, 8'h00, 8'h00},
                  {8'h00, 8'h00, 8'hFC, 8'hFC, 8'h00, 8'h00}};
        tbl[1] = {8'd6,
                  {8'hFF, 8'hFF, 8'hF7, 8'hFF, 8'hFF, 8'hFF},
                  {8'hC4, 8'hC4, 8'hC4, 8'hFC, 8'h00, 8'h00},
                  {8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'h00, 8'h00}};
        tbl[2] = {8'd6,
                  {8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00},
                  {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  {8'h00, 8'h1C, 8'h1C, 8'h1C, 8'h00, 8'h00}};

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, -1, -1);

        for (int t = 0; t < 3; t++) begin
            clear_g();
            g_n = int'(tbl[t].h);
            for (int l = 0; l < 6; l++) begin
                g_img[l] = {8'h00, tbl[t].img[l]};
                g_ee[l]  = {8'h00, tbl[t].ero[l]};
                g_ed[l]  = {8'h00, tbl[t].dil[l]};
            end
            run_case($sformatf("table%0d", t));
        end

        // overlong lines, then a normal line reading the buffered columns
        clear_g();
        g_n = 5;
        for (int l = 0; l < 4; l++) begin
            g_w[l] = 10; g_img[l] = 16'h03FF;
        end
        g_img[4] = 16'h00DF;
        g_ee[2] = 16'h00FC; g_ee[3] = 16'h00FC; g_ee[4] = 16'h001C;
        g_ed[2] = 16'h00FC; g_ed[3] = 16'h00FC; g_ed[4] = 16'h00FC;
        run_case("overlong");

        // one-cycle reset inside line 3 at column 4
        clear_g();
        g_n = 7; g_rst_line = 3; g_rst_col = 4;
        for (int l = 0; l < 7; l++) g_img[l] = 16'h00FF;
        g_ee[2] = 16'h00FC; g_ee[3] = 16'h0004; g_ee[5] = 16'h00FC; g_ee[6] = 16'h00FC;
        for (int l = 0; l < 7; l++) g_ed[l] = g_ee[l];
        run_case("reset_mid");

        // vsync restart before line 5
        clear_g();
        g_n = 9; g_vs_line = 5;
        for (int l = 0; l < 9; l++) g_img[l] = 16'h00FF;
        g_ee[2] = 16'h00FC; g_ee[3] = 16'h00FC; g_ee[4] = 16'h00FC;
        g_ee[7] = 16'h00FC; g_ee[8] = 16'h00FC;
        for (int l = 0; l < 9; l++) g_ed[l] = g_ee[l];
        run_case("vsync_mid");

        // random frames: widths up to 10, random density, rare resets and vsync restarts
        for (int f = 0; f < 40; f++) begin
            int w, h, dens;
            w    = $urandom_range(3, 10);
            h    = $urandom_range(1, 6);
            dens = $urandom_range(1, 3);
            vsync_pulse();
            for (int l = 0; l < h; l++) begin
                if ($urandom_range(0, 15) == 0) vsync_pulse();
                for (int c = 0; c < w; c++)
                    step($urandom_range(0, 79) == 0, 0, 0, 1, $urandom_range(0, 3) < dens, -1, -1);
                blank();
            end
        end
        blank();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
